// File: rtl/rate_controller_if.sv
// Button/indicator bundle between the rate controller and the counter/display datapath.
// The controller takes the master side; the datapath (or a bench) takes the slave side.
interface rate_controller_if;
  logic       btn;
  logic       tick;
  logic [1:0] mode;
  logic       press;
  logic       clear;

  modport master (input btn, output tick, output mode, output press, output clear);
  modport slave  (output btn, input tick, input mode, input press, input clear);
endinterface

// File: rtl/rate_controller.sv
// Debounced push-button rate controller: short presses step the speed mode, a long
// press forces STOP and requests a counter clear, and a prescaler emits the tick enable.
module rate_controller #(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter int DIV_SLOW          = 50000000,
  parameter int DIV_MED           = 12500000,
  parameter int DIV_FAST          = 3125000
) (
  input  logic              clk,
  input  logic              reset,
  rate_controller_if.master rc
);

  localparam int MAX_AB  = (DIV_SLOW > DIV_MED) ? DIV_SLOW : DIV_MED;
  localparam int MAX_DIV = (MAX_AB > DIV_FAST) ? MAX_AB : DIV_FAST;
  localparam int PW      = $clog2(MAX_DIV);
  localparam int DW      = $clog2(DEBOUNCE_CYCLES);
  localparam int HW      = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    STOP = 2'd0,
    SLOW = 2'd1,
    MED  = 2'd2,
    FAST = 2'd3
  } mode_e;

  logic          btn_meta_r, btn_sync_r, btn_db_r, btn_db_d_r;
  logic [DW-1:0] db_cnt_r;
  logic [HW-1:0] hold_r;
  logic          long_done_r;
  mode_e         mode_r, mode_next_s;
  logic [PW-1:0] presc_r, div_last_s;
  logic          tick_r, press_r, clear_r;
  logic          fall_s, press_s, clear_s, mode_change_s, presc_hit_s, tick_s;

  // A release only counts as a short press if the hold did not already fire a clear.
  assign fall_s        = btn_db_d_r & ~btn_db_r;
  assign press_s       = fall_s & ~long_done_r;
  assign clear_s       = btn_db_r & (hold_r == HOLD_LAST);
  assign mode_change_s = press_s | clear_s;
  assign presc_hit_s   = (mode_r != STOP) && (presc_r == div_last_s);
  assign tick_s        = presc_hit_s & ~mode_change_s;

  // Next mode: a long press wins over everything, a short press steps with wrap.
  always_comb begin
    mode_next_s = mode_r;
    if (clear_s) begin
      mode_next_s = STOP;
    end else if (press_s) begin
      case (mode_r)
        STOP:    mode_next_s = SLOW;
        SLOW:    mode_next_s = MED;
        MED:     mode_next_s = FAST;
        FAST:    mode_next_s = STOP;
        default: mode_next_s = STOP;
      endcase
    end else begin
      mode_next_s = mode_r;
    end
  end

  // Terminal prescaler count for the active run mode.
  always_comb begin
    div_last_s = {PW{1'b0}};
    case (mode_r)
      SLOW:    div_last_s = PW'(DIV_SLOW - 1);
      MED:     div_last_s = PW'(DIV_MED - 1);
      FAST:    div_last_s = PW'(DIV_FAST - 1);
      default: div_last_s = {PW{1'b0}};
    endcase
  end

  // Synchronizer and debounce of the raw button.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
      btn_db_r   <= 1'b0;
      btn_db_d_r <= 1'b0;
      db_cnt_r   <= {DW{1'b0}};
    end else begin
      btn_meta_r <= rc.btn;
      btn_sync_r <= btn_meta_r;
      btn_db_d_r <= btn_db_r;
      if (btn_sync_r != btn_db_r) begin
        if (db_cnt_r == DB_LAST) begin
          btn_db_r <= btn_sync_r;
          db_cnt_r <= {DW{1'b0}};
        end else begin
          db_cnt_r <= db_cnt_r + DW'(1);
        end
      end else begin
        db_cnt_r <= {DW{1'b0}};
      end
    end
  end

  // Hold duration and the long-press latch that suppresses the release press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_r      <= {HW{1'b0}};
      long_done_r <= 1'b0;
    end else begin
      if (!btn_db_r) begin
        hold_r <= {HW{1'b0}};
      end else if (hold_r != HOLD_MAX) begin
        hold_r <= hold_r + HW'(1);
      end else begin
        hold_r <= hold_r;
      end
      if (clear_s) begin
        long_done_r <= 1'b1;
      end else if (!btn_db_r) begin
        long_done_r <= 1'b0;
      end else begin
        long_done_r <= long_done_r;
      end
    end
  end

  // Mode register, prescaler and registered output pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_r  <= STOP;
      presc_r <= {PW{1'b0}};
      tick_r  <= 1'b0;
      press_r <= 1'b0;
      clear_r <= 1'b0;
    end else begin
      mode_r <= mode_next_s;
      if (mode_change_s || (mode_r == STOP) || presc_hit_s) begin
        presc_r <= {PW{1'b0}};
      end else begin
        presc_r <= presc_r + PW'(1);
      end
      tick_r  <= tick_s;
      press_r <= press_s;
      clear_r <= clear_s;
    end
  end

  assign rc.tick  = tick_r;
  assign rc.mode  = mode_r;
  assign rc.press = press_r;
  assign rc.clear = clear_r;

endmodule

// File: tb/tb_rate_controller.sv
// Self-checking bench for rate_controller: event-timestamp reference model compared every
// cycle, directed scenarios with literal latencies, then randomized button/reset traffic.
module tb_rate_controller;
  localparam int D = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic reset;
  rate_controller_if rc ();

  rate_controller #(
    .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L),
    .DIV_SLOW(8), .DIV_MED(4), .DIV_FAST(2)
  ) dut (
    .clk(clk), .reset(reset), .rc(rc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit model_ok = 1'b0;

  // Reference model state: timestamps of debounced edges and mode changes.
  logic       hist [64];
  logic       m_db;
  bit         m_long;
  int         last_flip, rise_t, fall_t, mode_t;
  logic [1:0] m_mode;
  logic       e_tick, e_press, e_clear;

  function automatic int div_of(input logic [1:0] m);
    case (m)
      2'd1:    return 8;
      2'd2:    return 4;
      2'd3:    return 2;
      default: return 1;
    endcase
  endfunction

  always @(posedge clk) begin
    bit flip, cl, pr, tk;
    cyc = cyc + 1;
    if (!reset) begin
      for (int i = 0; i < 64; i++) hist[i] = 1'b0;
      m_db = 1'b0; m_long = 1'b0; m_mode = 2'd0;
      last_flip = cyc; rise_t = -1000; fall_t = -1000; mode_t = cyc;
      e_tick = 1'b0; e_press = 1'b0; e_clear = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      // The synchronized level seen at edge t is the button sampled at edge t-2.
      flip = (cyc - last_flip >= D);
      for (int k = 0; k < D; k++)
        if (hist[(cyc - 2 - k) & 63] == m_db) flip = 1'b0;
      cl = m_db && (cyc - rise_t == L);
      pr = !m_db && (fall_t == cyc - 1) && !m_long;
      tk = (m_mode != 2'd0) && !cl && !pr && ((cyc - mode_t) % div_of(m_mode) == 0);
      if (cl) begin
        m_mode = 2'd0; mode_t = cyc; m_long = 1'b1;
      end else if (pr) begin
        m_mode = m_mode + 2'd1; mode_t = cyc;
      end
      if (flip) begin
        m_db = ~m_db; last_flip = cyc;
        if (m_db) begin rise_t = cyc; m_long = 1'b0; end
        else fall_t = cyc;
      end
      hist[cyc & 63] = rc.btn;
      e_tick = tk; e_press = pr; e_clear = cl;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if (rc.tick !== e_tick || rc.press !== e_press || rc.clear !== e_clear || rc.mode !== m_mode) begin
        errors++;
        $display("FAIL cycle %0d outputs tick/press/clear/mode got %b%b%b/%0d expected %b%b%b/%0d",
                 cyc, rc.tick, rc.press, rc.clear, rc.mode, e_tick, e_press, e_clear, m_mode);
      end
    end
  end

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Short press: hold high, release, and return the cycle the press pulse is seen.
  task automatic do_press(input int hi, input int exp_mode, output int pc);
    int dc;
    rc.btn = 1'b1;
    step(hi);
    rc.btn = 1'b0;
    dc = cyc;
    pc = -1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (rc.press === 1'b1) begin pc = cyc; break; end
    end
    check_int("press_latency", pc - dc, 7);
    check_int("mode_after_press", int'(rc.mode), exp_mode);
  endtask

  task automatic tick_gaps(input int start, input int n, input int div);
    int last = start;
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (rc.tick === 1'b1) begin
        check_int("tick_gap", cyc - last, div);
        last = cyc;
        seen++;
      end
    end
    check_int("tick_seen", int'(seen > 0), 1);
  endtask

  initial begin
    int pc, dc, cnt, clear_cyc, ticks_after;
    rc.btn = 1'b0;
    reset  = 1'b0;
    repeat (3) begin @(negedge clk); rc.btn = ~rc.btn; end
    rc.btn = 1'b0;
    reset  = 1'b1;
    step(1);
    check_int("reset_mode", int'(rc.mode), 0);
    check_int("reset_tick", int'(rc.tick), 0);

    // Bounce shorter than the debounce window.
    rc.btn = 1'b1; step(3); rc.btn = 1'b0; step(2); rc.btn = 1'b1; step(2); rc.btn = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin step(1); if (rc.press === 1'b1) cnt++; end
    check_int("bounce_press", cnt, 0);
    check_int("bounce_mode", int'(rc.mode), 0);

    // Four short presses cycle the mode fully.
    do_press(8, 1, pc); step(3);
    do_press(8, 2, pc); step(3);
    do_press(8, 3, pc); step(3);
    do_press(8, 0, pc); step(3);

    // Tick rate in SLOW, then MED.
    do_press(8, 1, pc);
    tick_gaps(pc, 40, 8);
    do_press(8, 2, pc);
    check_int("no_tick_on_mode_change", int'(rc.tick), 0);
    tick_gaps(pc, 24, 4);

    // Long press from MED.
    rc.btn = 1'b1; dc = cyc; cnt = 0; clear_cyc = -1; ticks_after = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (rc.clear === 1'b1) begin
        cnt++; clear_cyc = cyc;
        check_int("long_mode_stop", int'(rc.mode), 0);
      end
      if (clear_cyc >= 0 && rc.tick === 1'b1) ticks_after++;
    end
    check_int("long_clear_latency", clear_cyc - dc, 26);
    check_int("long_clear_count", cnt, 1);
    check_int("long_ticks_after", ticks_after, 0);
    rc.btn = 1'b0; cnt = 0;
    for (int i = 0; i < 15; i++) begin step(1); if (rc.press === 1'b1) cnt++; end
    check_int("long_release_press", cnt, 0);
    check_int("long_release_mode", int'(rc.mode), 0);

    // Reset in FAST with the prescaler at 1.
    do_press(8, 1, pc); step(3);
    do_press(8, 2, pc); step(3);
    do_press(8, 3, pc);
    step(1);
    reset = 1'b0; step(1); reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(1); if (rc.tick === 1'b1) cnt++; end
    check_int("reset_fast_ticks", cnt, 0);
    check_int("reset_fast_mode", int'(rc.mode), 0);

    // Reset at hold=15 with the button still held, then release as a fresh short press.
    rc.btn = 1'b1;
    step(21);
    reset = 1'b0; step(1); reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(1); if (rc.clear === 1'b1) cnt++; end
    check_int("reset_hold_clear", cnt, 0);
    rc.btn = 1'b0; dc = cyc; pc = -1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (rc.press === 1'b1) begin pc = cyc; break; end
    end
    check_int("fresh_press_latency", pc - dc, 7);
    check_int("fresh_press_mode", int'(rc.mode), 1);

    // Randomized button levels with occasional resets.
    for (int seg = 0; seg < 200; seg++) begin
      int len = $urandom_range(1, 35);
      rc.btn = $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0;
      for (int i = 0; i < len; i++) begin
        reset = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
        step(1);
      end
    end
    reset = 1'b1;
    rc.btn = 1'b0;
    step(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rate_controller.md
# rate_controller

Button-driven rate controller for the 3-bit counter/display datapath. Debounces the user push-button, classifies short and long presses, and steps through a four-level speed mode. Emits a single-cycle `tick` enable at the selected rate plus a `clear` request. Replaces the free-running speed/mux clock selection: the counter runs on `clk` and advances only on `tick`.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive cycles a synchronized button level must differ from the debounced level before it is accepted (≥2)
- `LONG_PRESS_CYCLES`, 25000000: debounced-high duration that qualifies as a long press (> DEBOUNCE_CYCLES)
- `DIV_SLOW`, 50000000: tick period in cycles, mode SLOW (≥2)
- `DIV_MED`, 12500000: tick period in cycles, mode MED (≥2)
- `DIV_FAST`, 3125000: tick period in cycles, mode FAST (≥2)
- `clk`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low; sampled on `clk` rising edge
- `btn`  in  1  raw push-button, active-high, asynchronous to `clk`
- `tick`  out  1  one-cycle counter enable
- `mode`  out  2  0=STOP, 1=SLOW, 2=MED, 3=FAST
- `press`  out  1  one-cycle pulse on accepted short press
- `clear`  out  1  one-cycle pulse on long press; counter clear request

## Operation
- Input path: 2-flop synchronizer `btn` → `btn_s`. Debounce counter increments while `btn_s != btn_db` and clears to 0 when they are equal. When it reaches DEBOUNCE_CYCLES-1 with `btn_s` still differing, `btn_db` takes `btn_s` on the next edge and the counter clears.
- Hold counter: cleared while `btn_db`=0. Increments while `btn_db`=1 and saturates at LONG_PRESS_CYCLES. A `long_done` flag is set on the cycle `clear` fires and cleared when `btn_db` falls.
- Long press: `clear`=1 for exactly one cycle on the edge at which the hold counter reaches LONG_PRESS_CYCLES. On that same edge `mode` is forced to STOP, regardless of the prior mode.
- Short press: `btn_db` falling edge with `long_done`=0.
  - `press`=1 for one cycle.
  - `mode` advances STOP→SLOW→MED→FAST→STOP (2-bit wrap).
- Falling edge with `long_done`=1: no `press`, no mode change.
- Prescaler, width = clog2(max DIV):
  - In STOP it is held at 0 and `tick`=0.
  - In a run mode it counts 0..DIV-1 for the active divisor. `tick`=1 on the cycle the count equals DIV-1, and the count wraps to 0 on the next edge.
- Mode change (press or forced STOP): prescaler loads 0 on the same edge `mode` updates. `tick` is 0 in that cycle, so no partial period is ever emitted.
- Reset (`reset`=0 at an edge): synchronizer, `btn_db`, all counters and `long_done` go to 0; `mode`=STOP; `tick`=`press`=`clear`=0.
  - Applies mid-press and mid-period with no residual pulse.
  - A button still held when reset is released is seen as a fresh press after the debounce delay.

## Timing
- All outputs are registered; reset value of every output is 0.
- `btn` change → `btn_db` change: 2 + DEBOUNCE_CYCLES cycles, provided the level is stable throughout. A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no change.
- `btn_db` fall → `press` and `mode` update: 1 cycle, both on the same edge.
- `btn_db` rise → `clear`: LONG_PRESS_CYCLES cycles. `mode`=STOP on that same edge.
- Entering a run mode: first `tick` is DIV cycles after the `mode` update edge, then one `tick` every DIV cycles.
- `tick` is never high for two consecutive cycles.
- `press` and `clear` are never both high, and never high in the same cycle as `tick`.
- Reset takes priority over every other event in the same cycle.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, DIV_SLOW=8, DIV_MED=4, DIV_FAST=2.
- Reset: hold `reset`=0 for 3 cycles with `btn` toggling → `mode`=0 and `tick`/`press`/`clear`=0 throughout and 1 cycle after release.
- Bounce: after reset, `btn` pulses high 3 cycles, low 2 cycles, high 2 cycles, then low → `btn_db` never rises; no `press`; `mode` stays 0.
- Short presses: four presses of 8 cycles high, 10 low → `press` fires 4 times. `mode` sequence 1,2,3,0, each update 2+4+1 cycles after `btn` falls.
- Tick rate: one short press, then observe 40 cycles → `mode`=1, ticks exactly 8 cycles apart, first tick 8 cycles after the mode edge. Second press → ticks every 4 cycles, with no tick on the mode-change cycle.
- Long press: in `mode`=2, hold `btn` high 40 cycles → single `clear` 20 cycles after `btn_db` rises, same edge `mode`=0, ticks stop. Release → no `press`, `mode` stays 0.
- Reset mid-operation: in `mode`=3 with prescaler at 1, and separately mid long-press at hold=15, assert `reset` 1 cycle → no `tick`/`clear` afterward. `mode`=0; `btn` still held → debounced as a new press.
